// File: rtl/shift_reg_ctl.sv
// Multi-mode WIDTH-bit register: load/clear/hold plus multi-cycle shift/rotate
// sequenced by a start/busy/done handshake, all gated by clk_en.
//
// state | meaning
// IDLE  | waiting for start; single-edge ops execute on acceptance
// RUN   | one shift/rotate step per enabled edge until the counter expires
// DONE  | one enabled cycle of done, then back to IDLE
module shift_reg_ctl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD  = 3'd0;
    localparam logic [2:0] M_LOAD  = 3'd1;
    localparam logic [2:0] M_SHL   = 3'd2;
    localparam logic [2:0] M_SHR   = 3'd3;
    localparam logic [2:0] M_ROTL  = 3'd4;
    localparam logic [2:0] M_ROTR  = 3'd5;
    localparam logic [2:0] M_ASHR  = 3'd6;
    localparam logic [2:0] M_CLEAR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             so_reg, so_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       op, op_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q_reg  <= '0;
            so_reg <= 1'b0;
            cnt    <= '0;
            op     <= M_HOLD;
        end else if (clk_en) begin
            state  <= state_next;
            q_reg  <= q_next;
            so_reg <= so_next;
            cnt    <= cnt_next;
            op     <= op_next;
        end
    end

    always_comb begin
        state_next = state;
        q_next     = q_reg;
        so_next    = so_reg;
        cnt_next   = cnt;
        op_next    = op;
        case (state)
            IDLE: begin
                if (start) begin
                    case (mode)
                        M_HOLD:  state_next = DONE;
                        M_LOAD: begin
                            q_next     = d;
                            state_next = DONE;
                        end
                        M_CLEAR: begin
                            q_next     = '0;
                            state_next = DONE;
                        end
                        default: begin
                            // Latch the operation so mode/amount may change while running.
                            op_next    = mode;
                            cnt_next   = amount;
                            state_next = (amount != '0) ? RUN : DONE;
                        end
                    endcase
                end
            end
            RUN: begin
                case (op)
                    M_SHL: begin
                        q_next  = {q_reg[WIDTH-2:0], ser_in};
                        so_next = q_reg[WIDTH-1];
                    end
                    M_SHR: begin
                        q_next  = {ser_in, q_reg[WIDTH-1:1]};
                        so_next = q_reg[0];
                    end
                    M_ROTL: begin
                        q_next  = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                        so_next = q_reg[WIDTH-1];
                    end
                    M_ROTR: begin
                        q_next  = {q_reg[0], q_reg[WIDTH-1:1]};
                        so_next = q_reg[0];
                    end
                    M_ASHR: begin
                        q_next  = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
                        so_next = q_reg[0];
                    end
                    default: ;
                endcase
                cnt_next = cnt - 1'b1;
                if (cnt == CNT_W'(1)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign q       = q_reg;
    assign q_      = ~q_reg;
    assign ser_out = so_reg;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule
